// File: rtl/dev_bus_pkg.sv
// Shared types and default address map for the device-bus controller.
package dev_bus_pkg;

  // Per-transaction handshake states
  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } dev_state_e;

  // Default physical map: on-chip RAM, external RAM, flash, serial port
  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] RAM_MASK    = 32'hffc0_0000;
  localparam logic [31:0] EXTRAM_BASE = 32'h0040_0000;
  localparam logic [31:0] EXTRAM_MASK = 32'hffc0_0000;
  localparam logic [31:0] FLASH_BASE  = 32'h1fc0_0000;
  localparam logic [31:0] FLASH_MASK  = 32'hffc0_0000;
  localparam logic [31:0] COM_BASE    = 32'h1fd0_03f8;
  localparam logic [31:0] COM_MASK    = 32'hffff_fff8;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/dev_addr_decode.sv
// Combinational priority address decoder: lowest-index matching slave wins.
module dev_addr_decode
  import dev_bus_pkg::*;
#(
  parameter int unsigned                      NUM_SLAVES = 4,
  parameter int unsigned                      ADDR_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]     SLAVE_BASE = {COM_BASE, FLASH_BASE,
                                                            EXTRAM_BASE, RAM_BASE},
  parameter logic [NUM_SLAVES*ADDR_W-1:0]     SLAVE_MASK = {COM_MASK, FLASH_MASK,
                                                            EXTRAM_MASK, RAM_MASK}
) (
  input  logic [ADDR_W-1:0]     addr_i,
  output logic [NUM_SLAVES-1:0] hit_o,
  output logic                  hit_any_o
);

  // Scan upward and keep only the first match so overlapping windows resolve
  always_comb begin
    hit_o     = '0;
    hit_any_o = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!hit_any_o &&
          ((addr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W])) begin
        hit_o[i]  = 1'b1;
        hit_any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dev_bus_ctrl.sv
// Device-bus controller: decodes CPU device requests onto N slave channels,
// runs a handshake with a watchdog and returns load data plus an error flag.
// Optional error log enabled by defining DEV_BUS_ERRLOG_EN.
module dev_bus_ctrl
  import dev_bus_pkg::*;
#(
  parameter int unsigned                  NUM_SLAVES     = 4,
  parameter int unsigned                  ADDR_W         = 32,
  parameter int unsigned                  DATA_W         = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE     = {COM_BASE, FLASH_BASE,
                                                            EXTRAM_BASE, RAM_BASE},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK     = {COM_MASK, FLASH_MASK,
                                                            EXTRAM_MASK, RAM_MASK},
  parameter int unsigned                  TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         devEnable_i,
  input  logic                         devWrite_i,
  input  logic [ADDR_W-1:0]            devPhysicalAddr_i,
  input  logic [DATA_W/8-1:0]          devByteSelect_i,
  input  logic [DATA_W-1:0]            devDataSave_i,
  output logic [DATA_W-1:0]            devDataLoad_o,
  output logic                         devBusy_o,
  output logic                         devError_o,
  output logic [NUM_SLAVES-1:0]        slvEnable_o,
  output logic                         slvWrite_o,
  output logic [ADDR_W-1:0]            slvAddr_o,
  output logic [DATA_W/8-1:0]          slvByteSelect_o,
  output logic [DATA_W-1:0]            slvDataSave_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] slvDataLoad_i,
  input  logic [NUM_SLAVES-1:0]        slvBusy_i
`ifdef DEV_BUS_ERRLOG_EN
  ,
  output logic                         errValid_o,
  output logic [ADDR_W-1:0]            errAddr_o,
  output logic                         errTimeout_o,
  input  logic                         errClear_i
`endif
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  dev_state_e              state_q, state_d;
  logic                    wr_q, wr_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W/8-1:0]     bsel_q, bsel_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [CntW-1:0]         cnt_q, cnt_d;

  logic [NUM_SLAVES-1:0]   hit;
  logic                    hit_any;
  logic [DATA_W-1:0]       sel_data;
  logic                    sel_busy;
  logic [CntW-1:0]         cnt_inc;

  dev_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .addr_i    (devPhysicalAddr_i),
    .hit_o     (hit),
    .hit_any_o (hit_any)
  );

  // Load-data mux and busy of the latched (one-hot) slave
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) sel_data = sel_data | slvDataLoad_i[i*DATA_W +: DATA_W];
    end
    sel_busy = |(slvBusy_i & sel_q);
    cnt_inc  = cnt_q + CntW'(1);
  end

  // Next-state logic for the handshake FSM and request/response registers
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    bsel_d  = bsel_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (devEnable_i) begin
          wr_d    = devWrite_i;
          addr_d  = devPhysicalAddr_i;
          bsel_d  = devByteSelect_i;
          wdata_d = devDataSave_i;
          sel_d   = hit;
          if (hit_any) begin
            state_d = StAccess;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StAccess: begin
        cnt_d = cnt_inc;
        if (!sel_busy) begin
          rdata_d = wr_q ? '0 : sel_data;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_inc == CntW'(TIMEOUT_CYCLES)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      bsel_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      bsel_q  <= bsel_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs: stall is combinational so it covers the request cycle itself
  always_comb begin
    devBusy_o       = devEnable_i & (state_q != StResp);
    devDataLoad_o   = (state_q == StResp) ? rdata_q : '0;
    devError_o      = (state_q == StResp) & err_q;
    slvEnable_o     = (state_q == StAccess) ? sel_q : '0;
    slvWrite_o      = wr_q;
    slvAddr_o       = addr_q;
    slvByteSelect_o = bsel_q;
    slvDataSave_o   = wdata_q;
  end

`ifdef DEV_BUS_ERRLOG_EN
  logic              err_valid_q, err_valid_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              err_to_q, err_to_d;

  // Sticky log of the first error; a coincident new error beats a clear.
  // Unmapped misses latch an all-zero selection, so a non-zero one means timeout.
  always_comb begin
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    err_to_d    = err_to_q;
    if ((state_q == StResp) && err_q) begin
      err_valid_d = 1'b1;
      if (!err_valid_q || errClear_i) begin
        err_addr_d = addr_q;
        err_to_d   = |sel_q;
      end
    end else if (errClear_i) begin
      err_valid_d = 1'b0;
    end
  end

  // Error-log registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_to_q    <= 1'b0;
    end else begin
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      err_to_q    <= err_to_d;
    end
  end

  assign errValid_o   = err_valid_q;
  assign errAddr_o    = err_addr_q;
  assign errTimeout_o = err_to_q;
`endif

endmodule

// File: tb/tb_dev_bus_ctrl.sv
// Self-checking bench for dev_bus_ctrl: table vectors, hand sequences for
// enable-drop and mid-access reset, then randomized transactions.
module tb_dev_bus_ctrl;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             devEnable_i;
  logic             devWrite_i;
  logic [AW-1:0]    devPhysicalAddr_i;
  logic [DW/8-1:0]  devByteSelect_i;
  logic [DW-1:0]    devDataSave_i;
  logic [DW-1:0]    devDataLoad_o;
  logic             devBusy_o;
  logic             devError_o;
  logic [NS-1:0]    slvEnable_o;
  logic             slvWrite_o;
  logic [AW-1:0]    slvAddr_o;
  logic [DW/8-1:0]  slvByteSelect_o;
  logic [DW-1:0]    slvDataSave_o;
  logic [NS*DW-1:0] slvDataLoad_i;
  logic [NS-1:0]    slvBusy_i;

  always #5 clk = ~clk;

  dev_bus_ctrl #(
    .NUM_SLAVES     (NS),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .devEnable_i       (devEnable_i),
    .devWrite_i        (devWrite_i),
    .devPhysicalAddr_i (devPhysicalAddr_i),
    .devByteSelect_i   (devByteSelect_i),
    .devDataSave_i     (devDataSave_i),
    .devDataLoad_o     (devDataLoad_o),
    .devBusy_o         (devBusy_o),
    .devError_o        (devError_o),
    .slvEnable_o       (slvEnable_o),
    .slvWrite_o        (slvWrite_o),
    .slvAddr_o         (slvAddr_o),
    .slvByteSelect_o   (slvByteSelect_o),
    .slvDataSave_o     (slvDataSave_o),
    .slvDataLoad_i     (slvDataLoad_i),
    .slvBusy_i         (slvBusy_i)
  );

  // Reference map (slave 0 first)
  logic [31:0] map_base [NS] = '{32'h0000_0000, 32'h0040_0000, 32'h1fc0_0000, 32'h1fd0_03f8};
  logic [31:0] map_mask [NS] = '{32'hffc0_0000, 32'hffc0_0000, 32'hffc0_0000, 32'hffff_fff8};

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  bsel;
    logic [31:0] wdata;
    int          w;      // busy cycles the target slave inserts
    logic [31:0] ldata;  // data on the target lane
    logic [3:0]  en;     // expected one-hot select
    logic        err;
    logic [31:0] data;
    int          lat;    // response cycle relative to request cycle
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one request starting at posedge+1; returns at posedge+1 after the response cycle.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [3:0] bsel,
                         input logic [31:0] wdata, input int w, input logic [NS*DW-1:0] lanes,
                         input logic [3:0] exp_en, input logic exp_err,
                         input logic [31:0] exp_data, input int exp_lat, input int drop_at);
    int idx = -1;
    for (int i = 0; i < NS; i++) if (exp_en[i]) idx = i;
    for (int c = 0; c <= exp_lat; c++) begin
      devEnable_i       = (drop_at < 0) || (c < drop_at);
      devWrite_i        = wr;
      devPhysicalAddr_i = addr;
      devByteSelect_i   = bsel;
      devDataSave_i     = wdata;
      slvDataLoad_i     = lanes;
      slvBusy_i         = 4'($urandom);
      if (idx >= 0) slvBusy_i[idx] = (c >= 1) && (c - 1 < w);
      @(negedge clk);
      if (c == 0) begin
        check("req_busy", devBusy_o, 1);
        check("req_slv_en", slvEnable_o, 0);
      end else if (c < exp_lat) begin
        check("acc_slv_en", slvEnable_o, exp_en);
        check("acc_busy", devBusy_o, devEnable_i);
        check("acc_addr", slvAddr_o, addr);
        check("acc_write", slvWrite_o, wr);
        if (wr) begin
          check("acc_wdata", slvDataSave_o, wdata);
          check("acc_bsel", slvByteSelect_o, bsel);
        end
      end else begin
        check("resp_busy", devBusy_o, 0);
        check("resp_err", devError_o, exp_err);
        check("resp_data", devDataLoad_o, exp_data);
        check("resp_slv_en", slvEnable_o, 0);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [NS*DW-1:0] lanes;
    logic [31:0]      addr;
    logic [3:0]       en;
    int               idx;
    int               w;
    int               lat;
    logic             wr;
    logic             err;
    logic [31:0]      data;

    rst_n = 1'b0;
    devEnable_i = 0; devWrite_i = 0; devPhysicalAddr_i = '0; devByteSelect_i = '0;
    devDataSave_i = '0; slvDataLoad_i = '0; slvBusy_i = '0;
    #2;
    check("rst_busy", devBusy_o, 0);
    check("rst_err", devError_o, 0);
    check("rst_data", devDataLoad_o, 0);
    check("rst_slv_en", slvEnable_o, 0);
    check("rst_slv_addr", slvAddr_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // The COM window lies inside the flash window, so flash (slave 2) wins 0x1fd003f8.
    tbl[0] = '{1'b0, 32'h0000_1000, 4'hf, 32'h0, 0, 32'hDEAD_BEEF, 4'b0001, 1'b0, 32'hDEAD_BEEF, 2};
    tbl[1] = '{1'b1, 32'h1fd0_03f8, 4'b0001, 32'h0000_00a5, 3, 32'h1234_5678, 4'b0100, 1'b0, 32'h0, 5};
    tbl[2] = '{1'b0, 32'h8000_0000, 4'hf, 32'h0, 0, 32'h1111_1111, 4'b0000, 1'b1, 32'h0, 1};
    tbl[3] = '{1'b0, 32'h0040_0000, 4'hf, 32'h0, 20, 32'hCAFE_F00D, 4'b0010, 1'b1, 32'h0, 17};
    tbl[4] = '{1'b0, 32'h0000_0004, 4'hf, 32'h0, 0, 32'h0BAD_F00D, 4'b0001, 1'b0, 32'h0BAD_F00D, 2};
    tbl[5] = '{1'b0, 32'h1fc0_0010, 4'hf, 32'h0, 1, 32'h5A5A_5A5A, 4'b0100, 1'b0, 32'h5A5A_5A5A, 3};
    tbl[6] = '{1'b0, 32'h007f_fffc, 4'hf, 32'h0, 15, 32'h7654_3210, 4'b0010, 1'b0, 32'h7654_3210, 17};
    tbl[7] = '{1'b0, 32'h0040_0100, 4'hf, 32'h0, 16, 32'h9999_0000, 4'b0010, 1'b1, 32'h0, 17};
    tbl[8] = '{1'b1, 32'h003f_fff0, 4'b1100, 32'h1122_3344, 2, 32'hAAAA_5555, 4'b0001, 1'b0, 32'h0, 4};
    tbl[9] = '{1'b0, 32'h2000_0000, 4'hf, 32'h0, 0, 32'h3333_3333, 4'b0000, 1'b1, 32'h0, 1};

    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < NS; i++)
        lanes[i*DW +: DW] = tbl[t].en[i] ? tbl[t].ldata : (tbl[t].ldata ^ 32'h0f0f_0000 ^ i);
      run_txn(tbl[t].wr, tbl[t].addr, tbl[t].bsel, tbl[t].wdata, tbl[t].w, lanes,
              tbl[t].en, tbl[t].err, tbl[t].data, tbl[t].lat, -1);
    end

    // Master drops enable mid-access; the slave access still completes
    lanes = {32'h4, 32'h3, 32'h2468_ace0, 32'h1};
    run_txn(1'b0, 32'h0040_0004, 4'hf, 32'h0, 2, lanes, 4'b0010, 1'b0, 32'h2468_ace0, 4, 2);

    // Reset asserted while a slave is being accessed
    devEnable_i = 1; devWrite_i = 0; devPhysicalAddr_i = 32'h0040_0000;
    slvBusy_i = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_slv_en", slvEnable_o, 4'b0010);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    devEnable_i = 0;
    #1;
    check("midrst_slv_en", slvEnable_o, 0);
    check("midrst_busy", devBusy_o, 0);
    check("midrst_err", devError_o, 0);
    check("midrst_data", devDataLoad_o, 0);
    check("midrst_addr", slvAddr_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    lanes = {32'h0, 32'h0, 32'h0, 32'h600D_0001};
    run_txn(1'b0, 32'h0000_0100, 4'hf, 32'h0, 1, lanes, 4'b0001, 1'b0, 32'h600D_0001, 3, -1);

    // Randomized transactions against an address-map / latency model
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 4);
      if (idx < NS) addr = map_base[idx] | ($urandom & ~map_mask[idx]);
      else          addr = $urandom;
      en = '0;
      for (int i = NS - 1; i >= 0; i--)
        if ((addr & map_mask[i]) == map_base[i]) en = 4'(1 << i);
      idx = -1;
      for (int i = 0; i < NS; i++) if (en[i]) idx = i;
      w  = $urandom_range(0, 18);
      wr = 1'($urandom);
      for (int i = 0; i < NS; i++) lanes[i*DW +: DW] = $urandom;
      if (idx < 0) begin
        lat = 1; err = 1'b1; data = '0;
      end else if (w >= TO) begin
        lat = TO + 1; err = 1'b1; data = '0;
      end else begin
        lat = w + 2; err = 1'b0; data = wr ? 32'h0 : lanes[idx*DW +: DW];
      end
      run_txn(wr, addr, 4'($urandom), $urandom, w, lanes, en, err, data, lat, -1);
    end

    devEnable_i = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
